// File: rtl/ts_sync_framer.sv
// ts_sync_framer: per-channel MPEG-2 TS packet framer.
// Hunts for the sync byte at packet spacing, locks after a run of hits, flywheels through
// isolated misses and drops lock after a run of misses. While locked, every valid byte is
// forwarded one cycle later with its in-packet index and a sync pulse on packet starts.
module ts_sync_framer #(
    parameter int unsigned PKT_LEN   = 188,
    parameter logic [7:0]  SYNC_BYTE = 8'h47,
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned LOSS_CNT  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       sync_out,
    output logic [7:0] byte_pos,
    output logic       locked,
    output logic       sync_err
);

    localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
    localparam int unsigned BadW  = $clog2(LOSS_CNT + 1);

    // Counter values at which the next event completes lock / drops lock.
    localparam logic [GoodW-1:0] LockLast = GoodW'(LOCK_CNT - 1);
    localparam logic [BadW-1:0]  LossLast = BadW'(LOSS_CNT - 1);
    localparam logic [7:0]       PosLast  = 8'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StVerify = 2'd1,
        StLock   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       pos_q, pos_d;
    logic [GoodW-1:0] good_q, good_d;
    logic [BadW-1:0]  bad_q, bad_d;

    logic [7:0] dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       sync_out_q, sync_out_d;
    logic [7:0] byte_pos_q, byte_pos_d;
    logic       sync_err_q, sync_err_d;

    logic       sync_match;
    logic [7:0] pos_inc;

    // Sync comparison and wrapping position increment.
    always_comb begin
        sync_match = (din == SYNC_BYTE);
        pos_inc    = (pos_q == PosLast) ? 8'd0 : pos_q + 8'd1;
    end

    // Next-state and registered-output decode; nothing moves on bubble cycles.
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        good_d       = good_q;
        bad_d        = bad_q;
        dout_d       = 8'd0;
        dout_valid_d = 1'b0;
        sync_out_d   = 1'b0;
        byte_pos_d   = 8'd0;
        sync_err_d   = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                StHunt: begin
                    // Only a sync byte starts a candidate alignment; pos stays 0 otherwise.
                    if (sync_match) begin
                        pos_d  = 8'd1;
                        good_d = GoodW'(1);
                        if (LOCK_CNT == 1) begin
                            state_d      = StLock;
                            bad_d        = '0;
                            dout_d       = din;
                            dout_valid_d = 1'b1;
                            sync_out_d   = 1'b1;
                        end else begin
                            state_d = StVerify;
                        end
                    end
                end

                StVerify: begin
                    pos_d = pos_inc;
                    if (pos_q == 8'd0) begin
                        if (sync_match) begin
                            good_d = good_q + GoodW'(1);
                            if (good_q == LockLast) begin
                                state_d      = StLock;
                                bad_d        = '0;
                                dout_d       = din;
                                dout_valid_d = 1'b1;
                                sync_out_d   = 1'b1;
                            end
                        end else begin
                            // False candidate; the failing byte is not re-examined.
                            state_d = StHunt;
                            good_d  = '0;
                            pos_d   = 8'd0;
                        end
                    end
                end

                StLock: begin
                    pos_d        = pos_inc;
                    dout_d       = din;
                    dout_valid_d = 1'b1;
                    byte_pos_d   = pos_q;
                    if (pos_q == 8'd0) begin
                        if (sync_match) begin
                            sync_out_d = 1'b1;
                            bad_d      = '0;
                        end else if (bad_q == LossLast) begin
                            // Loss of lock: this byte is not forwarded.
                            state_d      = StHunt;
                            good_d       = '0;
                            bad_d        = '0;
                            pos_d        = 8'd0;
                            dout_d       = 8'd0;
                            dout_valid_d = 1'b0;
                            sync_err_d   = 1'b1;
                        end else begin
                            // Flywheel: keep the expected framing and flag the miss.
                            bad_d      = bad_q + BadW'(1);
                            sync_out_d = 1'b1;
                            sync_err_d = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = StHunt;
                    pos_d   = 8'd0;
                    good_d  = '0;
                    bad_d   = '0;
                end
            endcase
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StHunt;
            pos_q        <= 8'd0;
            good_q       <= '0;
            bad_q        <= '0;
            dout_q       <= 8'd0;
            dout_valid_q <= 1'b0;
            sync_out_q   <= 1'b0;
            byte_pos_q   <= 8'd0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_out_q   <= sync_out_d;
            byte_pos_q   <= byte_pos_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sync_out   = sync_out_q;
    assign byte_pos   = byte_pos_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == StLock);

endmodule

// File: tb/tb_ts_sync_framer.sv
// Self-checking bench for ts_sync_framer: directed TS scenarios plus randomized streams,
// compared cycle by cycle against a byte-level framing model.
module tb_ts_sync_framer;

    localparam int unsigned PKT_LEN  = 188;
    localparam logic [7:0]  SYNC     = 8'h47;
    localparam int unsigned LOCK_CNT = 3;
    localparam int unsigned LOSS_CNT = 3;

    localparam int ModeHunt   = 0;
    localparam int ModeVerify = 1;
    localparam int ModeLock   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'd0;
    logic       din_valid = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       sync_out;
    logic [7:0] byte_pos;
    logic       locked;
    logic       sync_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: framing mode, index of next expected byte, hit/miss runs.
    int m_mode   = ModeHunt;
    int m_pos    = 0;
    int m_hits   = 0;
    int m_misses = 0;

    // Expected registered outputs for the current cycle.
    bit       e_valid;
    bit       e_sync;
    bit       e_err;
    bit [7:0] e_dout;
    bit [7:0] e_pos;

    ts_sync_framer #(
        .PKT_LEN  (PKT_LEN),
        .SYNC_BYTE(SYNC),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .dout      (dout),
        .dout_valid(dout_valid),
        .sync_out  (sync_out),
        .byte_pos  (byte_pos),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    task automatic model_reset();
        m_mode   = ModeHunt;
        m_pos    = 0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Apply the framing rules to one input slot and set the expected outputs.
    task automatic model_byte(input bit [7:0] b, input bit v);
        e_valid = 0; e_sync = 0; e_err = 0; e_dout = 0; e_pos = 0;
        if (!v) return;
        if (m_mode == ModeHunt) begin
            if (b == SYNC) begin
                m_hits = 1;
                m_pos  = 1 % PKT_LEN;
                if (m_hits >= LOCK_CNT) begin
                    m_mode = ModeLock; m_misses = 0;
                    e_valid = 1; e_sync = 1; e_dout = b; e_pos = 0;
                end else begin
                    m_mode = ModeVerify;
                end
            end
        end else if (m_mode == ModeVerify) begin
            if (m_pos == 0 && b != SYNC) begin
                m_mode = ModeHunt; m_hits = 0; m_pos = 0;
                return;
            end
            if (m_pos == 0) begin
                m_hits++;
                if (m_hits >= LOCK_CNT) begin
                    m_mode = ModeLock; m_misses = 0;
                    e_valid = 1; e_sync = 1; e_dout = b; e_pos = 0;
                end
            end
            m_pos = (m_pos + 1) % PKT_LEN;
        end else begin
            e_valid = 1; e_dout = b; e_pos = 8'(m_pos);
            if (m_pos == 0) begin
                if (b == SYNC) begin
                    e_sync = 1; m_misses = 0;
                end else begin
                    m_misses++;
                    e_err = 1;
                    if (m_misses >= LOSS_CNT) begin
                        e_valid = 0; e_dout = 0; e_pos = 0;
                        model_reset();
                        return;
                    end
                    e_sync = 1;
                end
            end
            m_pos = (m_pos + 1) % PKT_LEN;
        end
    endtask

    // Drive one cycle and compare the registered outputs after the edge.
    task automatic step(input bit [7:0] b, input bit v);
        din       = b;
        din_valid = v;
        model_byte(b, v);
        @(posedge clk);
        #1;
        check("dout_valid", 32'(dout_valid), 32'(e_valid));
        check("sync_out", 32'(sync_out), 32'(e_sync));
        check("sync_err", 32'(sync_err), 32'(e_err));
        check("locked", 32'(locked), 32'(m_mode == ModeLock));
        if (e_valid) begin
            check("dout", 32'(dout), 32'(e_dout));
            check("byte_pos", 32'(byte_pos), 32'(e_pos));
        end
    endtask

    function automatic bit [7:0] rand_byte(input bit no_sync);
        bit [7:0] b;
        b = 8'($urandom);
        while (no_sync && b == SYNC) b = 8'($urandom);
        return b;
    endfunction

    // vmode 0: always valid; 1: valid/bubble alternating; 2: random bubbles.
    task automatic send_byte(input bit [7:0] b, input int vmode);
        if (vmode == 2) begin
            while ($urandom_range(3) == 0) step(8'($urandom), 0);
        end
        step(b, 1);
        if (vmode == 1) step(8'($urandom), 0);
    endtask

    task automatic send_packet(input bit [7:0] first, input bit no_sync, input int vmode);
        send_byte(first, vmode);
        for (int i = 1; i < PKT_LEN; i++) send_byte(rand_byte(no_sync), vmode);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, 32'(dout), 32'd0);
        check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
        check({tag, "_sync_out"}, 32'(sync_out), 32'd0);
        check({tag, "_byte_pos"}, 32'(byte_pos), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_sync_err"}, 32'(sync_err), 32'd0);
    endtask

    initial begin
        // Reset values.
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Clean stream: lock on the third sync, then steady framing.
        for (int p = 0; p < 5; p++) send_packet(SYNC, 1, 0);
        check("locked_clean", 32'(locked), 32'd1);

        // Single corrupted syncs flywheel; clean syncs in between clear the miss run.
        send_packet(8'h00, 1, 0);
        send_packet(SYNC, 1, 0);
        send_packet(8'h00, 1, 0);
        send_packet(8'h12, 1, 0);
        send_packet(SYNC, 1, 0);
        check("flywheel_locked", 32'(locked), 32'd1);

        // Three consecutive misses drop lock; then re-lock on three clean syncs.
        for (int p = 0; p < 3; p++) send_packet(8'h00, 1, 0);
        check("loss_unlocked", 32'(locked), 32'd0);
        for (int p = 0; p < 4; p++) send_packet(SYNC, 1, 0);
        check("relock", 32'(locked), 32'd1);

        // Mid-packet async reset, then false sync in payload offset 50 during hunt.
        for (int i = 0; i < 100; i++) send_byte(rand_byte(1), 0);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        din_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 1; i < PKT_LEN; i++) send_byte((i == 50) ? SYNC : rand_byte(1), 0);
        for (int p = 0; p < 2; p++) send_packet(SYNC, 1, 0);
        check("false_sync_unlocked", 32'(locked), 32'd0);
        for (int p = 0; p < 4; p++) send_packet(SYNC, 1, 0);
        check("false_sync_relock", 32'(locked), 32'd1);

        // Alternating bubbles: spacing counts valid bytes only.
        for (int p = 0; p < 4; p++) send_packet(SYNC, 1, 1);
        check("toggle_locked", 32'(locked), 32'd1);

        // Randomized stream: random bubbles, occasional bad syncs, 0x47 allowed in payload.
        for (int p = 0; p < 24; p++) begin
            send_packet(($urandom_range(5) == 0) ? rand_byte(1) : SYNC, 0, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
